// File: rtl/cordic_pkg.sv
// Shared definitions for the cosine CORDIC accelerator: float32 field layout,
// the common fixed-point angle format, and the stage-1 unpack record.
package cordic_pkg;

    localparam int FLOAT_BIAS   = 127;
    localparam int FLOAT_MANT_W = 23;
    localparam int FLOAT_EXP_W  = 8;
    localparam int SIG_W        = FLOAT_MANT_W + 1;

    localparam int CORDIC_FRAC_BITS = 20;
    localparam int CORDIC_INT_BITS  = 2;

    typedef struct packed {
        logic                    valid;
        logic                    sign;
        logic                    special;
        logic [FLOAT_EXP_W-1:0]  exp;
        logic [SIG_W-1:0]        mant;
    } unpack_t;

    // Zero and denormal exponents collapse to a zero significand.
    function automatic logic [SIG_W-1:0] significand(
        input logic [FLOAT_EXP_W-1:0]  e,
        input logic [FLOAT_MANT_W-1:0] f
    );
        logic [SIG_W-1:0] m;
        if (e == {FLOAT_EXP_W{1'b0}}) begin
            m = {SIG_W{1'b0}};
        end else begin
            m = {1'b1, f};
        end
        return m;
    endfunction

endpackage

// File: rtl/cordic_fp_shift.sv
// Combinational signed-amount barrel shifter: positive amounts shift left,
// negative amounts shift right with truncation; flags results >= 2^OUT_W.
module cordic_fp_shift
    import cordic_pkg::*;
#(
    parameter int OUT_W   = CORDIC_INT_BITS + CORDIC_FRAC_BITS,
    parameter int SHIFT_W = FLOAT_EXP_W + 2
) (
    input  logic [SIG_W-1:0]          mant,
    input  logic signed [SHIFT_W-1:0] shift,
    output logic [OUT_W-1:0]          value,
    output logic                      overflow
);

    localparam int WIDE_W = SIG_W + OUT_W;

    logic [SHIFT_W-1:0] mag_s;
    logic [WIDE_W-1:0]  wide_s;
    logic               far_s;

    // Wide intermediate keeps every bit so overflow is judged before truncation.
    always_comb begin
        wide_s = {WIDE_W{1'b0}};
        far_s  = 1'b0;
        if (shift[SHIFT_W-1]) begin
            mag_s  = $unsigned(-shift);
            wide_s = WIDE_W'(mant) >> mag_s;
        end else begin
            mag_s = $unsigned(shift);
            if (mag_s > SHIFT_W'(OUT_W)) begin
                far_s = |mant;
            end else begin
                wide_s = WIDE_W'(mant) << mag_s;
            end
        end
        value    = wide_s[OUT_W-1:0];
        overflow = far_s | (|wide_s[WIDE_W-1:OUT_W]);
    end

endmodule

// File: rtl/cordic_fp_to_fixed.sv
// Two-stage float32 -> unsigned fixed-point angle converter feeding the CORDIC
// pipeline: stage 1 unpacks the operand, stage 2 scales and clamps it.
module cordic_fp_to_fixed
    import cordic_pkg::*;
#(
    parameter int FRAC_BITS = CORDIC_FRAC_BITS,
    parameter int INT_BITS  = CORDIC_INT_BITS
) (
    input  logic                          clock,
    input  logic                          aclr,
    input  logic                          clk_en,
    input  logic [31:0]                   dataa,
    input  logic                          in_valid,
    output logic [INT_BITS+FRAC_BITS-1:0] angle,
    output logic                          angle_sign,
    output logic                          angle_sat,
    output logic                          out_valid
);

    localparam int OUT_W   = INT_BITS + FRAC_BITS;
    localparam int SHIFT_W = FLOAT_EXP_W + 2;
    localparam logic signed [SHIFT_W-1:0] SHIFT_OFF =
        SHIFT_W'(FLOAT_BIAS + FLOAT_MANT_W - FRAC_BITS);

    unpack_t                     s1_r;
    logic signed [SHIFT_W-1:0]   shift_s;
    logic [OUT_W-1:0]            value_s;
    logic                        ovf_s;
    logic                        sat_s;

    // Stage 1: split the float into sign, exponent and significand.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            s1_r <= '0;
        end else if (clk_en) begin
            s1_r.valid   <= in_valid;
            s1_r.sign    <= dataa[31];
            s1_r.exp     <= dataa[30:23];
            s1_r.special <= (dataa[30:23] == 8'hFF);
            s1_r.mant    <= significand(dataa[30:23], dataa[22:0]);
        end
    end

    assign shift_s = $signed({2'b00, s1_r.exp}) - SHIFT_OFF;

    cordic_fp_shift #(
        .OUT_W   (OUT_W),
        .SHIFT_W (SHIFT_W)
    ) u_shift (
        .mant     (s1_r.mant),
        .shift    (shift_s),
        .value    (value_s),
        .overflow (ovf_s)
    );

    // Inf/NaN and out-of-range magnitudes clamp to full scale.
    always_comb begin
        sat_s = 1'b0;
        if (s1_r.special || ovf_s) begin
            sat_s = 1'b1;
        end else begin
            sat_s = 1'b0;
        end
    end

    // Stage 2: registered scaled magnitude and flags.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            angle      <= {OUT_W{1'b0}};
            angle_sign <= 1'b0;
            angle_sat  <= 1'b0;
            out_valid  <= 1'b0;
        end else if (clk_en) begin
            angle      <= sat_s ? {OUT_W{1'b1}} : value_s;
            angle_sign <= s1_r.sign;
            angle_sat  <= sat_s;
            out_valid  <= s1_r.valid;
        end
    end

endmodule

// File: tb/tb_cordic_fp_to_fixed.sv
// Scoreboard bench for cordic_fp_to_fixed: a real-arithmetic reference model
// predicts each accepted operand; a negedge monitor checks order and latency.
module tb_cordic_fp_to_fixed;

    localparam int FRAC_BITS = 20;
    localparam int INT_BITS  = 2;
    localparam int OUT_W     = FRAC_BITS + INT_BITS;

    typedef struct {
        logic [OUT_W-1:0] angle;
        logic             sign;
        logic             sat;
        int               tag;
    } exp_t;

    logic             clock = 1'b0;
    logic             aclr;
    logic             clk_en;
    logic [31:0]      dataa;
    logic             in_valid;
    logic [OUT_W-1:0] angle;
    logic             angle_sign;
    logic             angle_sat;
    logic             out_valid;

    exp_t             sb[$];
    int               edge_cnt = 0;
    bit               en_edge  = 1'b0;
    bit               hold_valid = 1'b0;
    logic [OUT_W-1:0] hold_angle = '0;
    int               n_checks = 0;
    int               n_pass   = 0;

    cordic_fp_to_fixed #(.FRAC_BITS(FRAC_BITS), .INT_BITS(INT_BITS)) dut (
        .clock      (clock),
        .aclr       (aclr),
        .clk_en     (clk_en),
        .dataa      (dataa),
        .in_valid   (in_valid),
        .angle      (angle),
        .angle_sign (angle_sign),
        .angle_sat  (angle_sat),
        .out_valid  (out_valid)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference: evaluate the real value of the float, clamp at 2^INT_BITS, truncate.
    function automatic exp_t model(input logic [31:0] x, input int tag);
        exp_t r;
        int   e;
        real  f, v;
        e = int'(x[30:23]);
        f = real'(x[22:0]);
        r.sign = x[31];
        r.tag  = tag;
        if (e == 255) begin
            r.sat = 1'b1;
        end else begin
            if (e == 0) v = f * (2.0 ** (-149));
            else        v = (1.0 + f / (2.0 ** 23)) * (2.0 ** (e - 127));
            r.sat = (v >= 2.0 ** INT_BITS);
            if (!r.sat) r.angle = OUT_W'($rtoi(v * (2.0 ** FRAC_BITS)));
        end
        if (r.sat) r.angle = {OUT_W{1'b1}};
        return r;
    endfunction

    // Record enabled edges and push the expectation for each accepted operand.
    always @(posedge clock) begin
        en_edge = clk_en && !aclr;
        if (en_edge) begin
            edge_cnt++;
            if (in_valid) sb.push_back(model(dataa, edge_cnt));
        end
    end

    // Monitor: compare outputs against the scoreboard away from the active edge.
    always @(negedge clock) begin
        exp_t e;
        bit   due;
        if (aclr) begin
            check("reset_valid", 32'(out_valid), 32'd0);
            check("reset_angle", 32'(angle), 32'd0);
            check("reset_flags", {30'd0, angle_sign, angle_sat}, 32'd0);
            hold_valid = 1'b0;
        end else if (en_edge) begin
            due = (sb.size() > 0) && (edge_cnt - sb[0].tag == 1);
            check("out_valid", 32'(out_valid), 32'(due));
            if (due) begin
                e = sb.pop_front();
                if (out_valid) begin
                    check("angle", 32'(angle), 32'(e.angle));
                    check("angle_sign", 32'(angle_sign), 32'(e.sign));
                    check("angle_sat", 32'(angle_sat), 32'(e.sat));
                end
                hold_angle = e.angle;
            end
            hold_valid = due;
        end else begin
            check("stall_valid", 32'(out_valid), 32'(hold_valid));
            if (hold_valid) check("stall_angle", 32'(angle), 32'(hold_angle));
        end
    end

    task automatic step(input logic en, input logic vld, input logic [31:0] d);
        clk_en   = en;
        in_valid = vld;
        dataa    = d;
        @(posedge clock);
        #1;
    endtask

    logic [31:0] dir_ops[] = '{
        32'h3F000000, 32'h3F800000, 32'h3DCCCCCD, 32'h3F666666,
        32'hBF800000, 32'h80000000, 32'h00000001, 32'h7F800000,
        32'h7FC00000, 32'h407FFFFF, 32'h40800000, 32'h40A00000,
        32'hFFC00000, 32'hC07FFFFF, 32'h3A800000, 32'h34800000
    };

    initial begin
        logic [31:0] rnd;
        aclr = 1'b1; clk_en = 1'b0; in_valid = 1'b0; dataa = 32'd0;
        #1;
        check("init_valid", 32'(out_valid), 32'd0);
        check("init_angle", 32'(angle), 32'd0);
        repeat (3) @(posedge clock);
        #1;
        aclr = 1'b0;
        repeat (3) step(1'b1, 1'b0, 32'd0);

        // Directed operands back-to-back.
        foreach (dir_ops[i]) step(1'b1, 1'b1, dir_ops[i]);
        repeat (3) step(1'b1, 1'b0, 32'd0);

        // Stall and bubble in the middle of a stream.
        step(1'b1, 1'b1, 32'h3F000000);
        step(1'b1, 1'b1, 32'h3F800000);
        repeat (3) step(1'b0, 1'b1, 32'h40A00000);
        step(1'b1, 1'b0, 32'h3F666666);
        step(1'b1, 1'b1, 32'h3DCCCCCD);
        step(1'b1, 1'b1, 32'hBF666666);
        repeat (3) step(1'b1, 1'b0, 32'd0);

        // Randomized operands, enable and valid.
        for (int i = 0; i < 400; i++) begin
            rnd = $urandom;
            if ($urandom_range(0, 9) < 7) rnd[30:23] = 8'($urandom_range(110, 132));
            step(($urandom_range(0, 4) != 0), ($urandom_range(0, 3) != 0), rnd);
        end
        repeat (3) step(1'b1, 1'b0, 32'd0);

        // Asynchronous reset with two operands in flight.
        step(1'b1, 1'b1, 32'h3F800000);
        step(1'b1, 1'b1, 32'h3F000000);
        aclr = 1'b1; clk_en = 1'b1; in_valid = 1'b0;
        sb.delete();
        #1;
        check("async_clr_valid", 32'(out_valid), 32'd0);
        check("async_clr_angle", 32'(angle), 32'd0);
        @(posedge clock);
        #1;
        aclr = 1'b0;
        repeat (4) step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h40490FDB);
        repeat (4) step(1'b1, 1'b0, 32'd0);

        check("drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cordic_fp_to_fixed.md
Name: cordic_fp_to_fixed

Overview:
- Upstream input stage of the cosine CORDIC accelerator.
- Takes IEEE-754 single-precision angles (radians) as delivered on the custom-instruction operand bus.
- Produces the unsigned fixed-point angle magnitude plus sign and saturation flags that the CORDIC iteration pipeline consumes.
- Cosine is even, so only the magnitude goes downstream; the sign is forwarded for diagnostics and for future sine support.

Parameters:
- FRAC_BITS, 20, fractional bits of the output angle.
- INT_BITS, 2, integer bits of the output angle (output width = INT_BITS+FRAC_BITS).

Ports:
- clock  input  1  system clock; all registers update on rising edge.
- aclr  input  1  asynchronous active-high reset.
- clk_en  input  1  pipeline advance enable; when low every register holds.
- dataa  input  32  float32 angle operand.
- in_valid  input  1  dataa carries a new operand this cycle (sampled only when clk_en=1).
- angle  output  INT_BITS+FRAC_BITS  unsigned fixed-point |x|, truncated toward zero.
- angle_sign  output  1  sign bit of the accepted operand.
- angle_sat  output  1  magnitude clamped (out of range, Inf or NaN).
- out_valid  output  1  angle/flags correspond to an accepted operand.

Behaviour:
- Reset: aclr high clears angle, angle_sign, angle_sat, out_valid and all internal stage registers to 0 immediately, without waiting for a clock edge. Operands in flight are discarded. Operation resumes on the first clk_en edge after aclr deasserts.
- Stall: with clk_en=0 every register, including the valid bits, holds its value.
- Latency: fixed 2 enabled clock edges from dataa/in_valid to angle/out_valid. With clk_en held high, throughput is one operand per cycle.
- in_valid=0 with clk_en=1 inserts a bubble: out_valid=0 two edges later. Data registers may take don't-care values in a bubble slot.
- Stage 1 (unpack), registered:
  - s = dataa[31].
  - e = dataa[30:23].
  - Significand M = {1, dataa[22:0]} (24 bits) when e≠0; M = 0 when e=0, so zero and denormals produce 0.
  - is_special = (e==255).
  - Valid bit.
- Stage 2 (scale/clamp), registered:
  - Shift k = e − (150 − FRAC_BITS), signed 9+ bits. With default FRAC_BITS=20, k = e − 130.
  - k ≥ 0: left shift M by k. k < 0: right shift M by −k, dropping bits (truncate). Right shift ≥ 24 yields 0.
  - Saturation: if is_special, or the exact scaled value ≥ 2^(INT_BITS+FRAC_BITS), then angle = all ones and angle_sat = 1. Otherwise angle_sat = 0. With defaults, saturation applies for |x| ≥ 4.0, i.e. e ≥ 129.
  - The overflow check is performed before truncating to the output width; wrap-around is forbidden.
  - angle_sign = s in all cases, including NaN.
- Negative zero gives angle = 0, angle_sign = 1, angle_sat = 0.
- Simultaneous aclr and clk_en: aclr wins.
- No backpressure input. Downstream consumes whenever out_valid=1 on an enabled edge.

Decomposition:
- Shared package/header cordic_pkg holds:
  - FLOAT_BIAS=127, FLOAT_MANT_W=23, FLOAT_EXP_W=8.
  - Default FRAC_BITS and INT_BITS, so this block and cordic_pipeline share one fixed-point format definition.
- Sub-module: cordic_fp_shift, a combinational signed-amount barrel shifter with overflow detect used in stage 2. It keeps the stage registers and valid logic in the top module.

Test Plan:
- Reset/idle: aclr=1 for 3 cycles, then aclr=0, clk_en=1, in_valid=0 -> angle=0, out_valid=0 throughout, including while aclr is still high.
- Nominal stream, back-to-back with clk_en=1:
  - 0x3F000000 -> 0x080000.
  - 0x3F800000 -> 0x100000.
  - 0x3DCCCCCD -> 0x019999.
  - 0x3F666666 -> 0x0E6666.
  - Each result appears exactly 2 edges after its input, with out_valid=1 and angle_sat=0.
- Sign and specials:
  - 0xBF800000 -> 0x100000, angle_sign=1.
  - 0x80000000 -> 0, angle_sign=1.
  - 0x00000001 -> 0.
  - 0x7F800000 -> 0x3FFFFF, angle_sat=1.
  - 0x7FC00000 -> 0x3FFFFF, angle_sat=1.
- Range boundary:
  - 0x407FFFFF (just below 4.0) -> 0x3FFFFF, angle_sat=0.
  - 0x40800000 (4.0) -> 0x3FFFFF, angle_sat=1.
  - 0x40A00000 (5.0) -> saturated, angle_sat=1.
- Stall and bubble: stream 4 operands, drop clk_en for 3 cycles mid-stream, and deassert in_valid for one slot -> outputs freeze during the stall, the bubble shows as out_valid=0, and no operand is lost or duplicated.
- Reset mid-operation: assert aclr asynchronously between edges while 2 operands are in flight -> outputs go to 0 before the next edge, and neither dropped operand ever appears at the output.
